// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB requester arbiter.
// Holds the transfer FSM state encoding and parameter defaults.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;
    localparam int DEFAULT_ADDR_WIDTH     = 32;
    localparam int DEFAULT_DATA_WIDTH     = 32;

    // Wait counter needs to reach TIMEOUT_CYCLES-1; keep at least one bit when disabled.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 1) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// APB bus signal bundle between the arbiter (master) and the slave.
interface apb_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin picker: one-hot grant when enabled, pointer holds the last winner.
module apb_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   ptr
);

    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan starting one past the last winner so every requester gets a turn.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + 1 + k) % NUM_REQ);
            if (en && !found && req[cand]) begin
                grant[cand] = 1'b1;
                win_idx     = cand;
                found       = 1'b1;
            end
        end
    end

    // Reset points at the highest index so requester 0 wins the first scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (found) begin
            ptr <= win_idx;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port among NUM_REQ requesters: round-robin grant,
// SETUP/ACCESS sequencing, PREADY wait-state timeout and response return.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          PCLK,
    input  logic                          PRESET_N,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    apb_req_arbiter_if.master             apb
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LAST_WAIT =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    apb_state_t            state;
    logic [CNT_W-1:0]      wait_cnt;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      ptr;
    logic [NUM_REQ-1:0]    owner;
    logic                  arb_en;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_write;

    // Grants only in IDLE, and never while reset is held so req_ready reads 0.
    assign arb_en    = (state == IDLE) && PRESET_N;
    assign req_ready = grant;
    // The pointer only moves on grant, so during a transfer it names the owner.
    assign owner     = NUM_REQ'(1) << ptr;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk   (PCLK),
        .rst_n (PRESET_N),
        .req   (req_valid),
        .en    (arb_en),
        .grant (grant),
        .ptr   (ptr)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr  |= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata |= req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_write |= req_write[i];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            apb.PWRITE  <= 1'b0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        apb.PADDR  <= sel_addr;
                        apb.PWDATA <= sel_wdata;
                        apb.PWRITE <= sel_write;
                        apb.PSEL   <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    apb.PENABLE <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (apb.PREADY) begin
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        rsp_valid   <= owner;
                        rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
                        rsp_err     <= apb.PSLVERR;
                        state       <= IDLE;
                    end else if (TIMEOUT_EN && (wait_cnt == LAST_WAIT)) begin
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        rsp_valid   <= owner;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: vector table, contention, reset
// during ACCESS and randomized traffic against a behavioural model.
module tb_apb_req_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int TMO  = 4;
    localparam int STUCK = 255;

    logic                 PCLK = 1'b0;
    logic                 PRESET_N;
    logic [NREQ-1:0]      req_valid, req_write, req_ready, rsp_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 PCLK = ~PCLK;

    apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb_req_arbiter #(
        .NUM_REQ        (NREQ),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET_N  (PRESET_N),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb)
    );

    // Slave: memory with programmable PREADY-low count and error injection.
    int unsigned wait_cfg = 0;
    logic        err_cfg  = 1'b0;
    logic        clear_mem = 1'b0;
    int unsigned acc_cnt  = 0;
    logic [DW-1:0] mem [256];

    always_comb begin
        apb.PREADY  = apb.PSEL && apb.PENABLE && (acc_cnt >= wait_cfg);
        apb.PSLVERR = apb.PREADY && err_cfg;
        apb.PRDATA  = mem[apb.PADDR[7:0]];
    end

    always @(posedge PCLK) begin
        if (apb.PSEL && apb.PENABLE && !apb.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (clear_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PWRITE && !err_cfg) begin
            mem[apb.PADDR[7:0]] <= apb.PWDATA;
        end
    end

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int unsigned   wait_n;
        logic          err;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vecs[9];
    logic [DW-1:0] ref_mem [256];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[r]           = v;
        req_write[r]           = w;
        req_addr[r*AW +: AW]   = a;
        req_wdata[r*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PRESET_N = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESET_N = 1'b1;
    endtask

    // One requester-0 transfer from the table, timed from the grant cycle.
    task automatic apply_stimulus(input vec_t v, input int id);
        int  n;
        bit  got, done, pat_ok;
        wait_cfg = v.wait_n;
        err_cfg  = v.err;
        @(posedge PCLK); #1;
        set_req(0, 1'b1, v.wr, v.addr, v.wdata);
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge PCLK);
            if (req_ready != 0) got = 1;
        end
        check_output($sformatf("vec%0d grant", id), req_ready, 2'b01);
        @(posedge PCLK); #1;
        req_valid[0] = 1'b0;
        n = 0; done = 0; pat_ok = 1;
        while (!done && n < 20) begin
            @(negedge PCLK);
            n++;
            if (rsp_valid != 0) done = 1;
            else if (apb.PSEL !== 1'b1 || apb.PENABLE !== (n >= 2) ||
                     apb.PADDR !== v.addr || apb.PWRITE !== v.wr) pat_ok = 0;
        end
        check_output($sformatf("vec%0d latency", id), n, v.exp_lat);
        check_output($sformatf("vec%0d psel pattern", id), pat_ok, 1);
        check_output($sformatf("vec%0d rsp_valid", id), rsp_valid, 2'b01);
        check_output($sformatf("vec%0d rdata", id), rsp_rdata, v.exp_rdata);
        check_output($sformatf("vec%0d err", id), rsp_err, v.exp_err);
        check_output($sformatf("vec%0d psel dropped", id), {apb.PSEL, apb.PENABLE}, 2'b00);
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int grants[$];
        int rsps[$];
        int cyc;
        bit got;

        foreach (ref_mem[i]) ref_mem[i] = '0;
        vecs[0] = '{1'b1, 16'h10, 32'hA5A5_0001, 0,     1'b0, 32'h0,         1'b0, 3};
        vecs[1] = '{1'b0, 16'h10, 32'h0,         0,     1'b0, 32'hA5A5_0001, 1'b0, 3};
        vecs[2] = '{1'b1, 16'h20, 32'h1234_5678, 1,     1'b0, 32'h0,         1'b0, 4};
        vecs[3] = '{1'b0, 16'h20, 32'h0,         3,     1'b0, 32'h1234_5678, 1'b0, 6};
        vecs[4] = '{1'b1, 16'h30, 32'hDEAD_BEEF, 0,     1'b1, 32'h0,         1'b1, 3};
        vecs[5] = '{1'b0, 16'h30, 32'h0,         0,     1'b0, 32'h0,         1'b0, 3};
        vecs[6] = '{1'b0, 16'h10, 32'h0,         STUCK, 1'b0, 32'h0,         1'b1, 6};
        vecs[7] = '{1'b1, 16'h44, 32'hCAFE_0000, 2,     1'b1, 32'h0,         1'b1, 5};
        vecs[8] = '{1'b0, 16'h20, 32'h0,         0,     1'b0, 32'h1234_5678, 1'b0, 3};

        // Reset state, with requests present to prove req_ready stays low.
        PRESET_N  = 1'b0;
        clear_mem = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        set_req(0, 1'b1, 1'b1, 16'h1234, 32'h5555_AAAA);
        set_req(1, 1'b1, 1'b0, 16'h4321, 32'hAAAA_5555);
        #12;
        check_output("reset apb ctrl", {apb.PSEL, apb.PENABLE, apb.PWRITE}, 3'b000);
        check_output("reset paddr", apb.PADDR, 0);
        check_output("reset pwdata", apb.PWDATA, 0);
        check_output("reset req_ready", req_ready, 0);
        check_output("reset rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        @(negedge PCLK);
        clear_mem = 1'b0;
        req_valid = '0;
        @(negedge PCLK);
        PRESET_N = 1'b1;

        foreach (vecs[i]) apply_stimulus(vecs[i], i);

        // Contention from reset: both held valid, expect 0,1,0,1.
        wait_cfg = 0; err_cfg = 1'b0;
        do_reset();
        @(posedge PCLK); #1;
        set_req(0, 1'b1, 1'b0, 16'h10, 32'h0);
        set_req(1, 1'b1, 1'b0, 16'h20, 32'h0);
        cyc = 0;
        while (rsps.size() < 4 && cyc < 60) begin
            @(negedge PCLK);
            cyc++;
            if (req_ready != 0) begin
                check_output("contention ready onehot", $onehot(req_ready), 1);
                grants.push_back(req_ready[1] ? 1 : 0);
            end
            if (rsp_valid != 0) rsps.push_back(rsp_valid[1] ? 1 : 0);
            if (grants.size() == 4 && req_valid != 0) begin
                @(posedge PCLK); #1;
                req_valid = '0;
            end
        end
        check_output("contention grant count", grants.size(), 4);
        check_output("contention rsp count", rsps.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            check_output($sformatf("contention grant%0d", i), grants[i], i % 2);
        for (int i = 0; i < rsps.size() && i < 4; i++)
            check_output($sformatf("contention rsp%0d", i), rsps[i], i % 2);

        // Reset during ACCESS after req0 won: pointer must return to req0.
        wait_cfg = STUCK;
        @(posedge PCLK); #1;
        set_req(0, 1'b1, 1'b0, 16'h50, 32'h0);
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge PCLK);
            if (req_ready[0]) got = 1;
        end
        check_output("rst-mid grant", req_ready, 2'b01);
        @(posedge PCLK); #1;
        req_valid = '0;
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge PCLK);
            if (apb.PENABLE === 1'b1) got = 1;
        end
        check_output("rst-mid reached access", got, 1);
        set_req(0, 1'b1, 1'b0, 16'h60, 32'h0);
        set_req(1, 1'b1, 1'b0, 16'h64, 32'h0);
        PRESET_N = 1'b0;
        #1;
        check_output("rst-mid psel/penable", {apb.PSEL, apb.PENABLE}, 2'b00);
        check_output("rst-mid rsp_valid", rsp_valid, 0);
        check_output("rst-mid req_ready", req_ready, 0);
        repeat (2) @(negedge PCLK);
        check_output("rst-mid no late rsp", rsp_valid, 0);
        wait_cfg = 0;
        PRESET_N = 1'b1;
        #1;
        check_output("rst-mid pointer reset", req_ready, 2'b01);
        @(posedge PCLK); #1;
        req_valid = '0;
        repeat (4) @(negedge PCLK);
        check_output("rst-mid completion", rsp_valid, 0);

        // Randomized traffic against a transaction-level model.
        begin
            int          last_g = 0;
            bit          busy = 0;
            int          exp_cycle = 0, exp_idx = 0, w, pick;
            logic [DW-1:0] exp_rdata;
            logic          exp_err, wr, er;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [NREQ-1:0] exp_ready, was_granted;
            int unsigned   wt, r;
            was_granted = '0;
            for (int c = 0; c < 1500; c++) begin
                @(posedge PCLK); #1;
                for (int q = 0; q < NREQ; q++) begin
                    if (was_granted[q] || c >= 1480) begin
                        req_valid[q]   = 1'b0;
                        was_granted[q] = 1'b0;
                    end else if (!req_valid[q]) begin
                        if ($urandom_range(0, 2) == 0)
                            set_req(q, 1'b1, 1'($urandom_range(0, 1)),
                                    AW'(16'h80 + 4 * $urandom_range(0, 15)), $urandom);
                    end else if ($urandom_range(0, 15) == 0) begin
                        req_valid[q] = 1'b0;
                    end
                end
                @(negedge PCLK);
                if (busy && c == exp_cycle) begin
                    check_output("rand rsp_valid", rsp_valid, NREQ'(1) << exp_idx);
                    check_output("rand rdata", rsp_rdata, exp_rdata);
                    check_output("rand err", rsp_err, exp_err);
                    busy = 0;
                end else begin
                    check_output("rand no rsp", rsp_valid, 0);
                end
                pick      = model_pick(req_valid, last_g);
                exp_ready = (busy || pick < 0) ? '0 : NREQ'(1) << pick;
                check_output("rand req_ready", req_ready, exp_ready);
                if (exp_ready != 0) begin
                    w = pick;
                    last_g = w;
                    busy = 1;
                    exp_idx = w;
                    was_granted[w] = 1'b1;
                    r  = $urandom_range(0, 9);
                    wt = (r == 0) ? STUCK : r % 4;
                    er = ($urandom_range(0, 5) == 0);
                    wait_cfg = wt;
                    err_cfg  = er;
                    wr = req_write[w];
                    a  = req_addr[w*AW +: AW];
                    d  = req_wdata[w*DW +: DW];
                    if (wt >= TMO) begin
                        exp_err   = 1'b1;
                        exp_rdata = '0;
                        exp_cycle = c + 2 + TMO;
                    end else begin
                        exp_err   = er;
                        exp_rdata = wr ? '0 : ref_mem[a[7:0]];
                        if (wr && !er) ref_mem[a[7:0]] = d;
                        exp_cycle = c + 3 + int'(wt);
                    end
                end
            end
            check_output("rand drained", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
